// File: rtl/rx_core_pkg.sv
// Shared widths, debug view codes and sample arithmetic helpers for the RX demodulator.
package rx_core_pkg;

  localparam int unsigned SampleW  = 16;
  localparam int unsigned InLanes  = 16;
  localparam int unsigned OutLanes = 8;
  localparam int unsigned InW      = SampleW * InLanes;
  localparam int unsigned OutW     = SampleW * OutLanes;

  localparam logic [2:0] DbgAdc = 3'd0;
  localparam logic [2:0] DbgCh1 = 3'd1;
  localparam logic [2:0] DbgCh2 = 3'd2;
  localparam logic [2:0] DbgCh3 = 3'd3;
  localparam logic [2:0] DbgCnt = 3'd4;

  // Two's-complement negate that maps the most negative value to the most positive.
  function automatic logic [SampleW-1:0] sat_neg(input logic [SampleW-1:0] x);
    if (x == {1'b1, {(SampleW-1){1'b0}}}) begin
      return {1'b0, {(SampleW-1){1'b1}}};
    end
    return ~x + 1'b1;
  endfunction

  // Full-precision sum of two signed samples, halved (floor) back to sample width.
  function automatic logic [SampleW-1:0] avg_pair(input logic [SampleW-1:0] a,
                                                  input logic [SampleW-1:0] b);
    logic [SampleW:0] sum;
    sum = {a[SampleW-1], a} + {b[SampleW-1], b};
    return sum[SampleW:1];
  endfunction

endpackage

// File: rtl/rx_channel.sv
// One output channel: phase accumulator, pair-average demodulator with sign flip, output FIFO.
module rx_channel
  import rx_core_pkg::*;
#(
  parameter int unsigned FifoDepth = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                enable_i,
  input  logic                accept_i,
  input  logic [InW-1:0]      data_i,
  input  logic [SampleW-1:0]  phase_inc_i,
  input  logic                tready_i,
  output logic                tvalid_o,
  output logic [OutW-1:0]     tdata_o,
  output logic                space_o
);

  localparam int unsigned PtrW = $clog2(FifoDepth);
  localparam logic [PtrW:0] Full = (PtrW + 1)'(FifoDepth);

  logic [PtrW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]      count_q;
  logic [SampleW-1:0] acc_q;
  logic [OutW-1:0]    mem_q [FifoDepth];
  logic [OutW-1:0]    demod;
  logic               push, pop;

  assign push     = accept_i & enable_i;
  assign pop      = tvalid_o & tready_i;
  assign tvalid_o = enable_i & (count_q != '0);
  assign tdata_o  = tvalid_o ? mem_q[rd_ptr_q] : '0;
  // A pop in the same cycle is deliberately not counted as free space.
  assign space_o  = (count_q != Full);

  always_comb begin
    demod = '0;
    for (int k = 0; k < OutLanes; k++) begin
      demod[SampleW*k +: SampleW] =
          acc_q[SampleW-1] ? sat_neg(avg_pair(data_i[SampleW*(2*k) +: SampleW],
                                              data_i[SampleW*(2*k+1) +: SampleW]))
                           : avg_pair(data_i[SampleW*(2*k) +: SampleW],
                                      data_i[SampleW*(2*k+1) +: SampleW]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      acc_q    <= '0;
    end else if (!enable_i) begin
      // Disabling flushes the queue and parks the accumulator at zero.
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      acc_q    <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
        acc_q    <= acc_q + phase_inc_i;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (!push && pop) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= demod;
    end
  end

endmodule

// File: rtl/rx_core.sv
// RF-ADC stream fan-out to three demodulating channels with backpressure and a debug view.
module rx_core
  import rx_core_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                adc_tvalid,
  input  logic [InW-1:0]      adc_tdata,
  output logic                adc_tready,
  input  logic [SampleW-1:0]  dds_phase_inc1,
  input  logic [SampleW-1:0]  dds_phase_inc2,
  input  logic [SampleW-1:0]  dds_phase_inc3,
  input  logic [2:0]          ch_enable,
  output logic [OutW-1:0]     ch1_tdata,
  output logic [OutW-1:0]     ch2_tdata,
  output logic [OutW-1:0]     ch3_tdata,
  output logic                ch1_tvalid,
  output logic                ch2_tvalid,
  output logic                ch3_tvalid,
  input  logic                ch1_tready,
  input  logic                ch2_tready,
  input  logic                ch3_tready,
  input  logic [2:0]          dbg_select,
  output logic [InW-1:0]      dbg_output_data
);

  logic [SampleW-1:0] phase_inc [3];
  logic [OutW-1:0]    ch_tdata [3];
  logic [2:0]         ch_tready, ch_tvalid, ch_space;
  logic               run_q, accept;
  logic [31:0]        accept_cnt_q, stall_cnt_q;
  logic [InW-1:0]     last_q, dbg_d;

  assign phase_inc[0] = dds_phase_inc1;
  assign phase_inc[1] = dds_phase_inc2;
  assign phase_inc[2] = dds_phase_inc3;
  assign ch_tready    = {ch3_tready, ch2_tready, ch1_tready};

  // run_q keeps the stream stalled until the first edge after reset release.
  assign adc_tready = run_q & (&(~ch_enable | ch_space));
  assign accept     = adc_tvalid & adc_tready;

  for (genvar c = 0; c < 3; c++) begin : g_ch
    rx_channel #(
      .FifoDepth (FIFO_DEPTH)
    ) u_channel (
      .clk_i       (clock),
      .rst_ni      (resetn),
      .enable_i    (ch_enable[c]),
      .accept_i    (accept),
      .data_i      (adc_tdata),
      .phase_inc_i (phase_inc[c]),
      .tready_i    (ch_tready[c]),
      .tvalid_o    (ch_tvalid[c]),
      .tdata_o     (ch_tdata[c]),
      .space_o     (ch_space[c])
    );
  end

  assign ch1_tvalid = ch_tvalid[0];
  assign ch2_tvalid = ch_tvalid[1];
  assign ch3_tvalid = ch_tvalid[2];
  assign ch1_tdata  = ch_tdata[0];
  assign ch2_tdata  = ch_tdata[1];
  assign ch3_tdata  = ch_tdata[2];

  always_comb begin
    dbg_d = '0;
    case (dbg_select)
      DbgAdc:  dbg_d = accept ? adc_tdata : last_q;
      DbgCh1:  dbg_d = {{(InW-OutW){1'b0}}, ch_tdata[0]};
      DbgCh2:  dbg_d = {{(InW-OutW){1'b0}}, ch_tdata[1]};
      DbgCh3:  dbg_d = {{(InW-OutW){1'b0}}, ch_tdata[2]};
      DbgCnt:  dbg_d = {{(InW-64){1'b0}}, stall_cnt_q, accept_cnt_q};
      default: dbg_d = '0;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      run_q           <= 1'b0;
      accept_cnt_q    <= '0;
      stall_cnt_q     <= '0;
      last_q          <= '0;
      dbg_output_data <= '0;
    end else begin
      run_q           <= 1'b1;
      dbg_output_data <= dbg_d;
      if (accept) begin
        accept_cnt_q <= accept_cnt_q + 1'b1;
        last_q       <= adc_tdata;
      end
      if (adc_tvalid && !adc_tready) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rx_core.sv
// Randomized bench for rx_core against a queue-based behavioural model, plus directed scenarios.
module tb_rx_core;

  localparam int FIFO_DEPTH = 4;

  logic         clock = 1'b0;
  logic         resetn;
  logic         adc_tvalid;
  logic [255:0] adc_tdata;
  logic         adc_tready;
  logic [15:0]  inc1, inc2, inc3;
  logic [2:0]   ch_enable;
  logic [127:0] ch1_tdata, ch2_tdata, ch3_tdata;
  logic         ch1_tvalid, ch2_tvalid, ch3_tvalid;
  logic         ch1_tready, ch2_tready, ch3_tready;
  logic [2:0]   dbg_select;
  logic [255:0] dbg_output_data;

  always #5 clock = ~clock;

  rx_core #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clock           (clock),
    .resetn          (resetn),
    .adc_tvalid      (adc_tvalid),
    .adc_tdata       (adc_tdata),
    .adc_tready      (adc_tready),
    .dds_phase_inc1  (inc1),
    .dds_phase_inc2  (inc2),
    .dds_phase_inc3  (inc3),
    .ch_enable       (ch_enable),
    .ch1_tdata       (ch1_tdata),
    .ch2_tdata       (ch2_tdata),
    .ch3_tdata       (ch3_tdata),
    .ch1_tvalid      (ch1_tvalid),
    .ch2_tvalid      (ch2_tvalid),
    .ch3_tvalid      (ch3_tvalid),
    .ch1_tready      (ch1_tready),
    .ch2_tready      (ch2_tready),
    .ch3_tready      (ch3_tready),
    .dbg_select      (dbg_select),
    .dbg_output_data (dbg_output_data)
  );

  // Behavioural model state
  logic [127:0] mq [3][$];
  logic [15:0]  macc [3];
  logic [31:0]  m_accepts, m_stalls;
  logic [255:0] m_last, m_dbg;
  bit           m_run;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Output lane k = floor((s[2k] + s[2k+1]) / 2), optionally negated with saturation.
  function automatic logic [127:0] model_demod(input logic [255:0] d, input bit neg);
    logic [127:0] r;
    logic [15:0]  sa, sb;
    int           a, b, v;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      sa = d[32*k +: 16];
      sb = d[32*k+16 +: 16];
      a  = int'($signed(sa));
      b  = int'($signed(sb));
      v  = (a + b) >>> 1;
      if (neg) v = (v == -32768) ? 32767 : -v;
      r[16*k +: 16] = v[15:0];
    end
    return r;
  endfunction

  task automatic model_clear();
    for (int c = 0; c < 3; c++) begin
      mq[c].delete();
      macc[c] = '0;
    end
    m_accepts = '0;
    m_stalls  = '0;
    m_last    = '0;
    m_dbg     = '0;
    m_run     = 1'b0;
  endtask

  // Entered just after a falling edge with this cycle's inputs applied; returns at the next one.
  task automatic cycle();
    bit           ready, acc;
    logic [2:0]   val, rdy;
    logic [127:0] td [3];
    logic [127:0] act_td [3];
    logic [2:0]   act_val;
    logic [15:0]  inc [3];
    #1;
    if (!resetn) model_clear();
    ready = m_run;
    for (int c = 0; c < 3; c++) begin
      if (ch_enable[c] && mq[c].size() >= FIFO_DEPTH) ready = 1'b0;
    end
    for (int c = 0; c < 3; c++) begin
      val[c] = resetn && ch_enable[c] && (mq[c].size() > 0);
      td[c]  = val[c] ? mq[c][0] : '0;
    end
    act_td[0] = ch1_tdata;
    act_td[1] = ch2_tdata;
    act_td[2] = ch3_tdata;
    act_val   = {ch3_tvalid, ch2_tvalid, ch1_tvalid};
    chk("adc_tready", adc_tready, ready);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("ch%0d_tvalid", c + 1), act_val[c], val[c]);
      chk($sformatf("ch%0d_tdata", c + 1), act_td[c], td[c]);
    end
    chk("dbg_output_data", dbg_output_data, m_dbg);

    if (resetn) begin
      rdy = {ch3_tready, ch2_tready, ch1_tready};
      inc[0] = inc1;
      inc[1] = inc2;
      inc[2] = inc3;
      acc = adc_tvalid && ready;
      case (dbg_select)
        3'd0:    m_dbg = acc ? adc_tdata : m_last;
        3'd1:    m_dbg = {128'b0, td[0]};
        3'd2:    m_dbg = {128'b0, td[1]};
        3'd3:    m_dbg = {128'b0, td[2]};
        3'd4:    m_dbg = {192'b0, m_stalls, m_accepts};
        default: m_dbg = '0;
      endcase
      if (acc) begin
        m_accepts = m_accepts + 1;
        m_last    = adc_tdata;
      end else if (adc_tvalid) begin
        m_stalls = m_stalls + 1;
      end
      for (int c = 0; c < 3; c++) begin
        if (!ch_enable[c]) begin
          mq[c].delete();
          macc[c] = '0;
        end else begin
          if (val[c] && rdy[c]) void'(mq[c].pop_front());
          if (acc) begin
            mq[c].push_back(model_demod(adc_tdata, macc[c][15]));
            macc[c] = macc[c] + inc[c];
          end
        end
      end
      m_run = 1'b1;
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic rand_inputs();
    adc_tvalid = ($urandom % 4) != 0;
    for (int i = 0; i < 8; i++) adc_tdata[32*i +: 32] = $urandom();
    if ($urandom % 8 == 0) adc_tdata[31:0] = 32'h8000_8000;
    if ($urandom % 40 == 0) ch_enable = 3'($urandom());
    if ($urandom % 16 == 0) begin
      inc1 = 16'($urandom());
      inc2 = 16'($urandom());
      inc3 = 16'($urandom());
    end
    ch1_tready = ($urandom % 4) != 0;
    ch2_tready = ($urandom % 3) != 0;
    ch3_tready = ($urandom % 2) != 0;
    dbg_select = 3'($urandom_range(0, 7));
  endtask

  initial begin
    logic [255:0] d;
    logic [127:0] pin;
    int seen;

    resetn = 1'b0; adc_tvalid = 1'b0; adc_tdata = '0;
    inc1 = '0; inc2 = '0; inc3 = '0; ch_enable = 3'b000;
    ch1_tready = 1'b0; ch2_tready = 1'b0; ch3_tready = 1'b0; dbg_select = 3'd0;
    model_clear();

    // Pin the model with hand-computed lanes
    d = '0;
    d[63:0] = 64'h7FFF_7FFF_FFFC_0003;
    pin = model_demod(d, 1'b0);
    chk("model_pin_pos", pin[31:0], 32'h7FFF_FFFF);
    d[63:0] = 64'h0000_0000_8000_8000;
    pin = model_demod(d, 1'b1);
    chk("model_pin_sat", pin[15:0], 16'h7FFF);

    @(negedge clock);
    cycle();
    cycle();
    chk("reset_tready", adc_tready, 1'b0);
    resetn = 1'b1;
    cycle();

    // Constant samples, zero increment
    ch_enable = 3'b001; ch1_tready = 1'b1;
    adc_tdata = {16{16'h0100}}; adc_tvalid = 1'b1;
    #1 chk("ready_one_enabled", adc_tready, 1'b1);
    cycle();
    adc_tvalid = 1'b0;
    chk("latency1_valid", ch1_tvalid, 1'b1);
    chk("const_data", ch1_tdata, {8{16'h0100}});
    cycle();

    // Half-turn increment flips every other beat; -(-32768) saturates
    inc1 = 16'h8000;
    adc_tdata = '0; adc_tdata[31:0] = 32'h8000_8000; adc_tvalid = 1'b1;
    cycle();
    chk("flip_beat0", ch1_tdata[15:0], 16'h8000);
    cycle();
    chk("flip_beat1", ch1_tdata[15:0], 16'h7FFF);
    cycle();
    chk("flip_beat2", ch1_tdata[15:0], 16'h8000);
    adc_tvalid = 1'b0; inc1 = '0;
    cycle();
    ch_enable = 3'b000;
    cycle();
    ch_enable = 3'b001;

    // Rounding toward minus infinity and positive full scale
    adc_tdata = '0; adc_tdata[63:0] = 64'h7FFF_7FFF_FFFC_0003; adc_tvalid = 1'b1;
    cycle();
    adc_tvalid = 1'b0;
    chk("avg_lanes", ch1_tdata[31:0], 32'h7FFF_FFFF);
    cycle();

    // Backpressure from a stalled channel
    ch_enable = 3'b111; ch2_tready = 1'b0; ch3_tready = 1'b1;
    inc2 = 16'd3; inc3 = 16'd5; dbg_select = 3'd4;
    adc_tvalid = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      adc_tdata = {8{$urandom()}};
      #1 if (adc_tready) seen++;
      cycle();
    end
    chk("bp_accepts", seen, 4);
    chk("bp_ready_low", adc_tready, 1'b0);
    adc_tvalid = 1'b0;
    cycle();
    chk("bp_counters", dbg_output_data, {192'b0, 32'd4, 32'd9});

    // Disable a channel that holds three beats
    ch_enable = 3'b100; ch3_tready = 1'b0; adc_tvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      adc_tdata = {8{$urandom()}};
      cycle();
    end
    adc_tvalid = 1'b0;
    chk("hold3_valid", ch3_tvalid, 1'b1);
    ch_enable = 3'b000;
    cycle();
    chk("disable_valid", ch3_tvalid, 1'b0);
    ch_enable = 3'b100;
    cycle();
    chk("reenable_empty", ch3_tvalid, 1'b0);

    for (int i = 0; i < 1500; i++) begin
      rand_inputs();
      cycle();
    end

    // Reset in the middle of traffic
    ch_enable = 3'b111;
    for (int i = 0; i < 6; i++) begin
      rand_inputs();
      ch_enable = 3'b111;
      cycle();
    end
    resetn = 1'b0;
    #1;
    chk("rst_tready", adc_tready, 1'b0);
    chk("rst_valids", {ch3_tvalid, ch2_tvalid, ch1_tvalid}, 3'b000);
    chk("rst_tdata", {ch3_tdata, ch2_tdata}, 256'b0);
    chk("rst_tdata1", ch1_tdata, 128'b0);
    chk("rst_dbg", dbg_output_data, 256'b0);
    cycle();
    resetn = 1'b1; dbg_select = 3'd4; adc_tvalid = 1'b0;
    cycle();
    chk("rst_counters", dbg_output_data, 256'b0);

    for (int i = 0; i < 300; i++) begin
      rand_inputs();
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
